// File: rtl/header_lock.sv
// Block-boundary lock for 64b/66b-style streams: hunts header offset, verifies, monitors loss.
// Optional HEADER_LOCK_STATS_EN adds slip and unlock statistics counters.
module header_lock #(
    parameter int BLOCK_W  = 66,
    parameter int HDR_W    = 2,
    parameter int LOCK_CNT = 32,
    parameter int WIN_CNT  = 64,
    parameter int BAD_MAX  = 16,
    parameter int OFF_W    = $clog2(BLOCK_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [2*BLOCK_W-1:0] buf_i,
    input  logic                 buf_dv_i,
    output logic [OFF_W-1:0]     offset_o,
    output logic [BLOCK_W-1:0]   block_o,
    output logic                 block_dv_o,
    output logic                 hdr_ok_o,
    output logic                 locked_o
`ifdef HEADER_LOCK_STATS_EN
    ,
    output logic [15:0]          slip_cnt_o,
    output logic [15:0]          unlock_cnt_o
`endif
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_CNT + 1);
    localparam int BAD_W  = $clog2(BAD_MAX + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [GOOD_W-1:0]  good_q, good_d, good_nxt;
    logic [WIN_W-1:0]   win_q, win_d, win_nxt;
    logic [BAD_W-1:0]   bad_q, bad_d, bad_nxt;
    logic [BLOCK_W-1:0] block_q, block_d;
    logic               block_dv_q, block_dv_d;
    logic               hdr_ok_q, hdr_ok_d;
    logic               locked_q, locked_d;

    logic [BLOCK_W-1:0] blk;
    logic [HDR_W-1:0]   hdr;
    logic               hdr_ok;
    logic               slip;
    logic               unlock;
    logic [OFF_W-1:0]   offset_inc;
    logic               unused_buf_lsb;

    // The lowest buffer bit can never start a block at any legal offset.
    assign unused_buf_lsb = buf_i[0];

    always_comb begin
        blk        = buf_i[(2*BLOCK_W-1-int'(offset_q)) -: BLOCK_W];
        hdr        = blk[BLOCK_W-1 -: HDR_W];
        hdr_ok     = (hdr == HDR_W'(1)) || (hdr == HDR_W'(2));
        offset_inc = (offset_q == OFF_W'(BLOCK_W-1)) ? '0 : offset_q + 1'b1;
        good_nxt   = good_q + 1'b1;
        win_nxt    = win_q + 1'b1;
        bad_nxt    = bad_q + BAD_W'(!hdr_ok);
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        good_d     = good_q;
        win_d      = win_q;
        bad_d      = bad_q;
        block_d    = block_q;
        hdr_ok_d   = hdr_ok_q;
        block_dv_d = buf_dv_i;
        slip       = 1'b0;
        unlock     = 1'b0;
        if (buf_dv_i) begin
            block_d  = blk;
            hdr_ok_d = hdr_ok;
            unique case (state_q)
                HUNT: begin
                    if (hdr_ok) begin
                        state_d = VERIFY;
                        good_d  = GOOD_W'(1);
                    end else begin
                        slip = 1'b1;
                    end
                end
                VERIFY: begin
                    if (!hdr_ok) begin
                        state_d = HUNT;
                        good_d  = '0;
                        slip    = 1'b1;
                    end else if (good_nxt == GOOD_W'(LOCK_CNT)) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_nxt;
                    end
                end
                LOCKED: begin
                    // Loss of lock outranks a window rollover on the same beat.
                    if (bad_nxt == BAD_W'(BAD_MAX)) begin
                        state_d = HUNT;
                        win_d   = '0;
                        bad_d   = '0;
                        slip    = 1'b1;
                        unlock  = 1'b1;
                    end else if (win_nxt == WIN_W'(WIN_CNT)) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_nxt;
                        bad_d = bad_nxt;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (slip) offset_d = offset_inc;
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            offset_q   <= '0;
            good_q     <= '0;
            win_q      <= '0;
            bad_q      <= '0;
            block_q    <= '0;
            block_dv_q <= 1'b0;
            hdr_ok_q   <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            good_q     <= good_d;
            win_q      <= win_d;
            bad_q      <= bad_d;
            block_q    <= block_d;
            block_dv_q <= block_dv_d;
            hdr_ok_q   <= hdr_ok_d;
            locked_q   <= locked_d;
        end
    end

    assign offset_o   = offset_q;
    assign block_o    = block_q;
    assign block_dv_o = block_dv_q;
    assign hdr_ok_o   = hdr_ok_q;
    assign locked_o   = locked_q;

`ifdef HEADER_LOCK_STATS_EN
    logic [15:0] slip_cnt_q, slip_cnt_d;
    logic [15:0] unlock_cnt_q, unlock_cnt_d;

    always_comb begin
        slip_cnt_d   = slip_cnt_q;
        unlock_cnt_d = unlock_cnt_q;
        if (slip && slip_cnt_q != 16'hFFFF) slip_cnt_d = slip_cnt_q + 16'd1;
        if (unlock && unlock_cnt_q != 16'hFFFF) unlock_cnt_d = unlock_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slip_cnt_q   <= '0;
            unlock_cnt_q <= '0;
        end else begin
            slip_cnt_q   <= slip_cnt_d;
            unlock_cnt_q <= unlock_cnt_d;
        end
    end

    assign slip_cnt_o   = slip_cnt_q;
    assign unlock_cnt_o = unlock_cnt_q;
`endif

endmodule

// File: tb/tb_header_lock.sv
// Directed bench for header_lock: vector table for the lock sequence plus hand sequences.
// Stream aligned at true offset 5; zero bits ahead of the block give invalid headers.
module tb_header_lock;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [131:0] buf_i;
    logic         buf_dv_i;
    logic [6:0]   offset_o;
    logic [65:0]  block_o;
    logic         block_dv_o;
    logic         hdr_ok_o;
    logic         locked_o;
`ifdef HEADER_LOCK_STATS_EN
    logic [15:0]  slip_cnt_o;
    logic [15:0]  unlock_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    header_lock dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .buf_i      (buf_i),
        .buf_dv_i   (buf_dv_i),
        .offset_o   (offset_o),
        .block_o    (block_o),
        .block_dv_o (block_dv_o),
        .hdr_ok_o   (hdr_ok_o),
        .locked_o   (locked_o)
`ifdef HEADER_LOCK_STATS_EN
        ,
        .slip_cnt_o   (slip_cnt_o),
        .unlock_cnt_o (unlock_cnt_o)
`endif
    );

    typedef struct {
        logic         rst;
        logic         dv;
        logic [131:0] bufv;
        logic [6:0]   e_off;
        logic         e_dv;
        logic         e_ok;
        logic         e_lock;
        logic         chk_blk;
        logic [65:0]  e_blk;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [65:0] mk(input logic [1:0] h, input logic [63:0] p);
        return {h, p};
    endfunction

    function automatic logic [131:0] place(input logic [65:0] b);
        logic [131:0] t;
        t = {b, 66'b0};
        return t >> 5;
    endfunction

    function automatic void add(input logic r, input logic d, input logic [131:0] b,
                                input logic [6:0] eo, input logic ed, input logic eok,
                                input logic el, input logic cb, input logic [65:0] eb);
        vec_t v;
        v.rst = r; v.dv = d; v.bufv = b; v.e_off = eo; v.e_dv = ed;
        v.e_ok = eok; v.e_lock = el; v.chk_blk = cb; v.e_blk = eb;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [131:0] b);
        @(negedge clk_i);
        rst_i    = r;
        buf_dv_i = d;
        buf_i    = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [6:0] eo, input logic ed,
                           input logic eok, input logic el);
        chk({tag, ".offset"}, 66'(offset_o), 66'(eo));
        chk({tag, ".dv"}, 66'(block_dv_o), 66'(ed));
        chk({tag, ".locked"}, 66'(locked_o), 66'(el));
        if (ed) chk({tag, ".hdr_ok"}, 66'(hdr_ok_o), 66'(eok));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, place(mk(2'b01, 64'h0)));
        chk_out("reset", 7'd0, 1'b0, 1'b0, 1'b0);
        chk("reset.block", block_o, 66'd0);
        chk("reset.hdr_ok", 66'(hdr_ok_o), 66'd0);
    endtask

    logic [65:0] good_blk;
    logic [65:0] bad_blk;
    logic [65:0] b;
    int          beats;
    int          cyc;

    initial begin
        rst_i    = 1'b1;
        buf_dv_i = 1'b0;
        buf_i    = '0;
        good_blk = mk(2'b01, 64'hC0FF_EE00_1234_5678);
        bad_blk  = mk(2'b00, 64'hDEAD_BEEF_0000_0001);

        add(1, 0, '0, 0, 0, 0, 0, 0, '0);
        add(1, 1, place(good_blk), 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            add(0, 1, place(good_blk), 7'(i + 1), 1, 0, 0, 0, '0);
            if (i == 2) add(0, 0, place(good_blk), 7'd3, 0, 0, 0, 0, '0);
        end
        for (int g = 1; g <= 32; g++) begin
            b = mk(2'b01, 64'hA5A5_0000_0000_0000 | 64'(g));
            add(0, 1, place(b), 7'd5, 1, 1, (g == 32), 1, b);
            if (g == 10) add(0, 0, place(bad_blk), 7'd5, 0, 0, 0, 0, '0);
        end
        add(0, 0, place(bad_blk), 7'd5, 0, 0, 1, 0, '0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].dv, vecs[i].bufv);
            chk_out($sformatf("vec%0d", i), vecs[i].e_off, vecs[i].e_dv,
                    vecs[i].e_ok, vecs[i].e_lock);
            if (vecs[i].chk_blk) chk($sformatf("vec%0d.block", i), block_o, vecs[i].e_blk);
        end

        // Window 1: 15 bad then 49 good keeps lock; window 2: 16th bad on last beat unlocks.
        for (int k = 0; k < 64; k++) begin
            drive(0, 1, place(k < 15 ? bad_blk : good_blk));
            chk_out($sformatf("win1_%0d", k), 7'd5, 1'b1, !(k < 15), 1'b1);
        end
        for (int k = 0; k < 64; k++) begin
            drive(0, 1, place(k >= 48 ? bad_blk : good_blk));
            chk_out($sformatf("win2_%0d", k), (k == 63) ? 7'd6 : 7'd5, 1'b1,
                    !(k >= 48), (k != 63));
        end
`ifdef HEADER_LOCK_STATS_EN
        chk("stats.slip_a", 66'(slip_cnt_o), 66'd6);
        chk("stats.unlock_a", 66'(unlock_cnt_o), 66'd1);
`endif

        // 31 good then one bad in VERIFY: back to hunting one offset later.
        do_reset();
        for (int i = 0; i < 5; i++) drive(0, 1, place(good_blk));
        chk("c.offset", 66'(offset_o), 66'd5);
        for (int g = 0; g < 31; g++) begin
            drive(0, 1, place(good_blk));
            chk_out($sformatf("c_good%0d", g), 7'd5, 1'b1, 1'b1, 1'b0);
        end
        drive(0, 1, place(bad_blk));
        chk_out("c_bad", 7'd6, 1'b1, 1'b0, 1'b0);
        drive(0, 0, place(good_blk));
        chk_out("c_idle", 7'd6, 1'b0, 1'b0, 1'b0);

        // Offset walks the full range and wraps.
        do_reset();
        for (int i = 0; i < 66; i++) begin
            drive(0, 1, '0);
            chk_out($sformatf("wrap%0d", i), 7'((i + 1) % 66), 1'b1, 1'b0, 1'b0);
        end

        // Reset mid-VERIFY, then a full restart.
        do_reset();
        for (int i = 0; i < 25; i++) drive(0, 1, place(good_blk));
        chk("e.pre_offset", 66'(offset_o), 66'd5);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, place(good_blk));
            chk_out($sformatf("e_hunt%0d", i), 7'(i + 1), 1'b1, 1'b0, 1'b0);
        end
        for (int g = 1; g <= 32; g++) begin
            drive(0, 1, place(good_blk));
            chk_out($sformatf("e_good%0d", g), 7'd5, 1'b1, 1'b1, (g == 32));
        end

        // Random idle gaps must not move the lock point counted in valid beats.
        do_reset();
        beats = 0;
        cyc   = 0;
        while (!locked_o && beats < 100 && cyc < 1000) begin
            for (int gap = int'($urandom_range(0, 3)); gap > 0; gap--) begin
                drive(0, 0, place(bad_blk));
                cyc++;
                chk("gap.dv", 66'(block_dv_o), 66'd0);
            end
            drive(0, 1, place(good_blk));
            beats++;
            cyc++;
        end
        chk("gap.lock_beat", 66'(beats), 66'd37);
        chk("gap.locked", 66'(locked_o), 66'd1);
        chk("gap.offset", 66'(offset_o), 66'd5);
`ifdef HEADER_LOCK_STATS_EN
        chk("stats.slip", 66'(slip_cnt_o), 66'd5);
        chk("stats.unlock", 66'(unlock_cnt_o), 66'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
